// File: rtl/sweeper_pkg.sv
// Shared types and sizing helpers for the minterm sweeper.
// The state encoding, default parameter values and width helpers live here so
// the top level and the settle timer agree on them.
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_SETTLE = 2;
    localparam logic [7:0] DEF_EXPECTED = 8'hE0;

    // Number of input codes swept for a given b_out width.
    function automatic int calcN(input int width);
        return 2 ** width;
    endfunction

    // Settle counter width; never less than one bit, even when SETTLE is 0.
    function automatic int calcCntW(input int settle);
        return (settle > 0) ? $clog2(settle + 1) : 1;
    endfunction

endpackage

// File: rtl/minterm_sweeper_settle_timer.sv
// Settle timer for the minterm sweeper.
// Counts idle cycles while the sweeper waits for the unit under test to settle.
// expire is raised on the last idle cycle, so the sample state follows it
// directly and every code is held for SETTLE+1 cycles in total.
module settle_timer
    import sweeper_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = calcCntW(SETTLE);
    localparam int LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    logic [CNT_W-1:0] r_count;

    // Expiry compare; with SETTLE = 0 the count sits at 0 and expire stays high.
    assign expire = (r_count == CNT_W'(LAST));

    // Count up while not cleared, saturating once expired so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!expire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/minterm_sweeper.sv
// Minterm sweeper: drives every input code onto b_out, samples the F output of
// the unit under test after a settle delay, and compares the collected truth
// table with EXPECTED.
// Optional build macro: MISMATCH_STOP_EN ends the sweep at the first code whose
// sampled F differs from EXPECTED, leaving b_out on the failing code.
module minterm_sweeper
    import sweeper_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter logic [(2**WIDTH)-1:0] EXPECTED = DEF_EXPECTED
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    f_in,
    output logic [WIDTH-1:0]        b_out,
    output logic                    busy,
    output logic                    done,
    output logic [(2**WIDTH)-1:0]   result,
    output logic                    match
);

    localparam int N = calcN(WIDTH);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_bOut;
    logic [N-1:0]     r_result;
    logic             r_match;

    logic             w_startSweep;
    logic             w_sample;
    logic             w_lastCode;
    logic             w_stop;
    logic             w_expire;
    logic             w_clearTimer;
    logic [N-1:0]     w_resultSampled;

    // The timer only runs in SETTLE; every other state holds it at zero.
    assign w_clearTimer = (r_state != ST_SETTLE);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settleTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clearTimer),
        .expire (w_expire)
    );

    assign w_lastCode = (r_bOut == WIDTH'(N - 1));

`ifdef MISMATCH_STOP_EN
    assign w_stop = w_lastCode || (f_in != EXPECTED[r_bOut]);
`else
    assign w_stop = w_lastCode;
`endif

    // Truth table as it will look once the current code's F value is stored.
    always_comb begin
        w_resultSampled         = r_result;
        w_resultSampled[r_bOut] = f_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; start is only honoured when no sweep is running.
    always_comb begin
        w_stateNext  = r_state;
        w_startSweep = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_startSweep = 1'b1;
                    w_stateNext  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_expire) begin
                    w_stateNext = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_stop) begin
                    w_stateNext = ST_DONE;
                end else begin
                    w_stateNext = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Code index, truth table and match flag; a stopping sample freezes b_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bOut   <= '0;
            r_result <= '0;
            r_match  <= 1'b0;
        end else if (w_startSweep) begin
            r_bOut   <= '0;
            r_result <= '0;
            r_match  <= 1'b0;
        end else if (w_sample) begin
            r_result <= w_resultSampled;
            if (w_stop) begin
                r_match <= (w_resultSampled == EXPECTED);
            end else begin
                r_bOut <= r_bOut + WIDTH'(1);
            end
        end
    end

    assign b_out  = r_bOut;
    assign result = r_result;
    assign busy   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done   = (r_state == ST_DONE);
    assign match  = r_match && done;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Testbench for minterm_sweeper with default parameters (WIDTH 3, SETTLE 2,
// EXPECTED 8'hE0). Honours MISMATCH_STOP_EN for the stuck-at-0 scenario.
// f_in comes from a behavioural model of the unit under test selected by mode.
module tb_minterm_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       f_in;
    logic [2:0] b_out;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       match;

    int mode;
    int checkCount;
    int passCount;

    minterm_sweeper dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .f_in   (f_in),
        .b_out  (b_out),
        .busy   (busy),
        .done   (done),
        .result (result),
        .match  (match)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unit under test: 0 -> B2&(B0|B1), 1 -> stuck at 0, 2 -> B0.
    always_comb begin
        case (mode)
            0:       f_in = b_out[2] & (b_out[0] | b_out[1]);
            1:       f_in = 1'b0;
            default: f_in = b_out[0];
        endcase
    end

    // Pulse start for one edge; returns at the falling edge of cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (b_out !== 3'd0) $display("[TB] FAIL reset_b_out: got %h expected 0", b_out);
        else passCount++;
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else passCount++;
        checkCount++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
        else passCount++;
        checkCount++;
        if (result !== 8'h00) $display("[TB] FAIL reset_result: got %h expected 00", result);
        else passCount++;
        checkCount++;
        if (match !== 1'b0) $display("[TB] FAIL reset_match: got %b expected 0", match);
        else passCount++;
        // start together with reset: reset must win
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_beats_start: busy got %b expected 0", busy);
        else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        logic [5:0] obs;
        logic [5:0] exp;
        mode = 0;
        pulse_start();
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            obs = {b_out, busy, done, match};
            if (c < 25) exp = {3'((c - 1) / 3), 1'b1, 1'b0, 1'b0};
            else        exp = {3'd7, 1'b0, 1'b1, 1'b1};
            checkCount++;
            if (obs !== exp) $display("[TB] FAIL full_sweep_c%0d {b_out,busy,done,match}: got %h expected %h", c, obs, exp);
            else passCount++;
        end
        checkCount++;
        if (result !== 8'hE0) $display("[TB] FAIL full_sweep_result: got %h expected e0", result);
        else passCount++;
    endtask

    task automatic test_stuck_zero();
        int doneCycle;
        logic [2:0] expB;
`ifdef MISMATCH_STOP_EN
        doneCycle = 19;
        expB = 3'd5;
`else
        doneCycle = 25;
        expB = 3'd7;
`endif
        mode = 1;
        pulse_start();
        for (int c = 1; c <= doneCycle; c++) begin
            if (c > 1) @(negedge clk);
            checkCount++;
            if (done !== (c == doneCycle)) $display("[TB] FAIL stuck0_done_c%0d: got %b expected %b", c, done, (c == doneCycle));
            else passCount++;
        end
        checkCount++;
        if (b_out !== expB) $display("[TB] FAIL stuck0_b_out: got %h expected %h", b_out, expB);
        else passCount++;
        checkCount++;
        if (result !== 8'h00) $display("[TB] FAIL stuck0_result: got %h expected 00", result);
        else passCount++;
        checkCount++;
        if ({busy, match} !== 2'b00) $display("[TB] FAIL stuck0_busy_match: got %b expected 00", {busy, match});
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs;
        logic [4:0] exp;
        mode = 0;
        pulse_start();
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == 10);
            obs = {b_out, busy, done};
            if (c < 25) exp = {3'((c - 1) / 3), 1'b1, 1'b0};
            else        exp = {3'd7, 1'b0, 1'b1};
            checkCount++;
            if (obs !== exp) $display("[TB] FAIL b2b_c%0d {b_out,busy,done}: got %h expected %h", c, obs, exp);
            else passCount++;
        end
        start = 1'b0;
        checkCount++;
        if ({result, match} !== {8'hE0, 1'b1}) $display("[TB] FAIL b2b_result_match: got %h/%b expected e0/1", result, match);
        else passCount++;
    endtask

    task automatic test_mid_reset();
        mode = 0;
        pulse_start();
        repeat (11) @(negedge clk);
        checkCount++;
        if (b_out !== 3'd3) $display("[TB] FAIL midrst_b_out_c12: got %h expected 3", b_out);
        else passCount++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkCount++;
        if ({b_out, busy, done, result, match} !== 14'd0)
            $display("[TB] FAIL midrst_cleared: got b_out=%h busy=%b done=%b result=%h match=%b expected all 0", b_out, busy, done, result, match);
        else passCount++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checkCount++;
            if ({busy, done} !== 2'b00) $display("[TB] FAIL midrst_idle_%0d {busy,done}: got %b expected 00", c, {busy, done});
            else passCount++;
        end
        pulse_start();
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            checkCount++;
            if (done !== (c == 25)) $display("[TB] FAIL midrst_sweep_done_c%0d: got %b expected %b", c, done, (c == 25));
            else passCount++;
        end
        checkCount++;
        if ({b_out, result, match} !== {3'd7, 8'hE0, 1'b1}) $display("[TB] FAIL midrst_final: got %h/%h/%b expected 7/e0/1", b_out, result, match);
        else passCount++;
    endtask

    task automatic test_restart_model();
        checkCount++;
        if ({done, result} !== {1'b1, 8'hE0}) $display("[TB] FAIL restart_pre: got done=%b result=%h expected 1/e0", done, result);
        else passCount++;
        mode = 2;
        pulse_start();
        checkCount++;
        if ({result, done, match, busy} !== {8'h00, 1'b0, 1'b0, 1'b1}) $display("[TB] FAIL restart_c1: got result=%h done=%b match=%b busy=%b expected 00/0/0/1", result, done, match, busy);
        else passCount++;
        repeat (24) @(negedge clk);
        checkCount++;
        if ({done, result, match} !== {1'b1, 8'hAA, 1'b0}) $display("[TB] FAIL restart_final: got done=%b result=%h match=%b expected 1/aa/0", done, result, match);
        else passCount++;
    endtask

    // Scenario sequence and summary.
    initial begin
        checkCount = 0;
        passCount = 0;
        mode = 0;
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_full_sweep();
        test_stuck_zero();
        test_back_to_back();
        test_mid_reset();
        test_restart_model();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
